// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-digit counter family.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  // Non-decimal codes 10-15 collapse to zero so q never shows them.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t i_d);
    bcd_digit_t r;
    if (i_d > BCD_MAX) r = 4'd0;
    else               r = i_d;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0-9 up or down and flags carry/borrow to the next decade.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_in,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t d,
  output bcd_digit_t q,
  output logic       step_out
);

  bcd_digit_t r_q;
  bcd_digit_t w_next;
  logic       w_at_edge;

  // Next value and whether this decade rolls over in the current direction.
  always_comb begin
    w_at_edge = 1'b0;
    w_next    = r_q;
    if (up) begin
      w_at_edge = (r_q == BCD_MAX);
      w_next    = w_at_edge ? 4'd0 : (r_q + 4'd1);
    end else begin
      w_at_edge = (r_q == 4'd0);
      w_next    = w_at_edge ? BCD_MAX : (r_q - 4'd1);
    end
  end

  assign step_out = step_in & w_at_edge;
  assign q        = r_q;

  // Digit register; clear beats load beats step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_q <= 4'd0;
    else if (clr)     r_q <= 4'd0;
    else if (load)    r_q <= bcd_sanitize(d);
    else if (step_in) r_q <= w_next;
    else              r_q <= r_q;
  end

endmodule

// File: rtl/bcd_counter_multi.sv
// DIGITS-decade packed-BCD up/down counter with terminal count and wrap pulse.
// Optional parallel load (load/d ports) is enabled by defining BCD_COUNTER_LOAD_EN.
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up,
  input  logic                          clr,
`ifdef BCD_COUNTER_LOAD_EN
  input  logic                          load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] d,
`endif
  output logic [BCD_DIGIT_W*DIGITS-1:0] q,
  output logic                          tc,
  output logic                          wrap
);

  logic                          w_load;
  logic [BCD_DIGIT_W*DIGITS-1:0] w_d;
  logic [DIGITS:0]               w_step;
  logic                          w_all9;
  logic                          w_all0;
  logic                          r_wrap;

`ifdef BCD_COUNTER_LOAD_EN
  assign w_load = load;
  assign w_d    = d;
`else
  assign w_load = 1'b0;
  assign w_d    = '0;
`endif

  // Digit k steps only when en is high and every lower decade is at its edge.
  assign w_step[0] = en;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .step_in  (w_step[g]),
      .up       (up),
      .clr      (clr),
      .load     (w_load),
      .d        (w_d[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .q        (q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .step_out (w_step[g+1])
    );
  end

  // Terminal-count detection across all decades.
  always_comb begin
    w_all9 = 1'b1;
    w_all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_all9 = w_all9 & (q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == BCD_MAX);
      w_all0 = w_all0 & (q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0);
    end
  end

  assign tc = up ? w_all9 : w_all0;

  // Wrap pulse: carry out of the top decade, suppressed by clear or load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_wrap <= 1'b0;
    else if (clr || w_load)  r_wrap <= 1'b0;
    else                     r_wrap <= w_step[DIGITS];
  end

  assign wrap = r_wrap;

endmodule

// File: doc/bcd_counter_multi.md
# bcd_counter_multi

Parametrised multi-digit BCD up/down counter, the successor to the single-digit 0–9 lab counter. It counts in packed BCD across DIGITS decades with ripple-free carry/borrow, and adds enable, direction, synchronous clear, an optional parallel load, a terminal-count flag and a wrap pulse. It is the timebase and display-value source for the seven-segment and stopwatch labs that follow.

## Interface
- DIGITS, default 2: number of BCD decades, 1–8; count range 0 to 10^DIGITS−1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; all state clears immediately while low.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 increments, 0 decrements.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load; present only with BCD_COUNTER_LOAD_EN.
- d  input  4*DIGITS  load value, digit 0 in bits [3:0]; present only with BCD_COUNTER_LOAD_EN.
- q  output  4*DIGITS  current count, packed BCD, digit 0 least significant.
- tc  output  1  terminal count, combinational: q is all 9s when up=1, or all 0s when up=0.
- wrap  output  1  registered one-cycle pulse; high in the cycle after a step that wrapped.

## Operation
- Priority on each rising edge: clr > load > en. With none of them active, q holds.
- Up step: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. Digit k changes only when all lower digits are 9.
- Down step: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. Digit k changes only when all lower digits are 0.
- Wrap, up direction: all 9s → all 0s. Wrap, down direction: all 0s → all 9s. In both cases wrap=1 on the following cycle.
- wrap is 0 after clr, after load, and whenever en=0.
- Changing up between cycles is legal. The next step uses the new direction, and tc re-evaluates combinationally.
- Digits always stay in 0–9. Codes 10–15 never appear on q.
- Reset: q=0 and wrap=0 asynchronously while rst is low. Deasserting rst mid-count resumes counting from 0 on the first edge with en=1.

## Timing
- q changes only on the rising clk edge, with 1-cycle latency from en, clr or load; the exception is asynchronous reset.
- tc follows q and up combinationally, with no added latency.
- wrap is registered: it is high exactly one cycle, in the cycle following the wrapping edge.
- With en held high, the counter wraps every 10^DIGITS cycles. Consecutive wraps are therefore separated by 10^DIGITS cycles.
- Reset values: q=0, wrap=0. tc = (up==0) while in reset.

## Configuration
- BCD_COUNTER_LOAD_EN defined:
  - load and d ports exist.
  - On load=1 (and clr=0), q ← d on the next edge.
  - Any d digit of 10–15 is loaded as 0. The other digits load unchanged.
  - wrap=0 in the load cycle.
- BCD_COUNTER_LOAD_EN undefined:
  - load and d ports are absent.
  - Priority reduces to clr > en.

## Structure
- Shared package bcd_pkg:
  - BCD_DIGIT_W = 4
  - BCD_MAX = 4'd9
  - digit typedef bcd_digit_t
  - function bcd_sanitize (maps 10–15 to 0)
- One sub-module per decade, bcd_digit:
  - Inputs: clk, rst, step_in, up, clr, load, d.
  - Outputs: q, step_out (carry/borrow to the next decade).
  - Instantiated DIGITS times in a generate loop. Carry/borrow is chained combinationally.
- The top level owns tc and the wrap register.

## Test plan
- DIGITS=2, reset low then high, en=1, up=1 for 100 cycles → q steps 00,01…99,00; wrap=1 only in the cycle after 99→00; tc=1 only at 99.
- DIGITS=2, up=0 from reset → first edge gives q=99, wrap=1 the next cycle; then 98, 97…
- q=39 with up=1 then en=1 → 40; with up=0 from 40 → 39 (carry/borrow across decades).
- Assert rst low mid-count at q=57, between clock edges → q=0 and wrap=0 immediately, without waiting for a clock edge; counting resumes from 00.
- clr=1 with en=1 at q=73 → q=00 and wrap=0; with load=1 at the same time, clr still wins.
- BCD_COUNTER_LOAD_EN, DIGITS=3, load d=0x9C5 → q=0x905; then en=1, up=1 → 0x906.
